// File: rtl/conv_seq_ctrl_if.sv
// Handshake/bus bundle between conv_seq_ctrl and its register block + memories/MAC.
// CONV_SEQ_CTRL_PERF_EN adds the cycles_o busy-cycle counter.
interface conv_seq_ctrl_if #(
  parameter int SIZE_W = 5
);
  logic              start_i;
  logic [SIZE_W-1:0] sizeX_i;
  logic [SIZE_W-1:0] sizeY_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [SIZE_W-1:0] addrX_o;
  logic [SIZE_W-1:0] addrY_o;
  logic              mac_en_o;
  logic              acc_clr_o;
  logic              zwe_o;
  logic [SIZE_W:0]   addrZ_o;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [15:0]       cycles_o;

  modport master (
    input  start_i, sizeX_i, sizeY_i,
    output busy_o, done_o, rd_en_o, addrX_o, addrY_o,
           mac_en_o, acc_clr_o, zwe_o, addrZ_o, cycles_o
  );
  modport slave (
    output start_i, sizeX_i, sizeY_i,
    input  busy_o, done_o, rd_en_o, addrX_o, addrY_o,
           mac_en_o, acc_clr_o, zwe_o, addrZ_o, cycles_o
  );
`else
  modport master (
    input  start_i, sizeX_i, sizeY_i,
    output busy_o, done_o, rd_en_o, addrX_o, addrY_o,
           mac_en_o, acc_clr_o, zwe_o, addrZ_o
  );
  modport slave (
    output start_i, sizeX_i, sizeY_i,
    input  busy_o, done_o, rd_en_o, addrX_o, addrY_o,
           mac_en_o, acc_clr_o, zwe_o, addrZ_o
  );
`endif
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks i over the output and k over the valid X/Y overlap,
// driving reads, MAC enable, accumulator clear and Z writes. Option: CONV_SEQ_CTRL_PERF_EN.
module conv_seq_ctrl #(
  parameter int SIZE_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  conv_seq_ctrl_if.master bus
);
  localparam int IW = SIZE_W + 1;
  localparam int SW = SIZE_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [SIZE_W-1:0] sx, sy, k;
  logic [IW-1:0]     i;
  logic              mac_en_q;

  logic signed [SW-1:0] kmin_s, ik_s;
  logic [SIZE_W-1:0]    kmin, kmax, addr_y;
  logic [SW-1:0]        last_i_val;
  logic                 size_zero, last_k, last_i;
  logic                 busy, done, rd_en, acc_clr, zwe;
  logic                 lint_unused;

  // Signed index math: a negative lower bound / Y index clamps to 0.
  assign kmin_s = signed'({1'b0, i}) - signed'({2'b00, sy}) + signed'(SW'(1));
  assign ik_s   = signed'({1'b0, i}) - signed'({2'b00, k});
  assign kmin   = (kmin_s < 0) ? '0 : kmin_s[SIZE_W-1:0];
  assign addr_y = (ik_s   < 0) ? '0 : ik_s[SIZE_W-1:0];
  assign kmax   = (i < {1'b0, sx}) ? i[SIZE_W-1:0] : sx - SIZE_W'(1);

  assign last_i_val = {2'b00, sx} + {2'b00, sy} - SW'(2);
  assign last_i     = ({1'b0, i} == last_i_val);
  assign last_k     = (k == kmax);
  assign size_zero  = (bus.sizeX_i == '0) || (bus.sizeY_i == '0);
  assign lint_unused = ^{kmin_s[SW-1:SIZE_W], ik_s[SW-1:SIZE_W]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    acc_clr   = 1'b0;
    zwe       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_nxt = size_zero ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        acc_clr   = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        rd_en = 1'b1;
        if (last_k) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_WRITE;
      S_WRITE: begin
        zwe       = 1'b1;
        state_nxt = last_i ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // mac_en trails rd_en by the one-cycle memory read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      sx       <= '0;
      sy       <= '0;
      k        <= '0;
      i        <= '0;
      mac_en_q <= 1'b0;
    end else begin
      mac_en_q <= rd_en;
      case (state)
        S_IDLE:  if (bus.start_i) begin
                   sx <= bus.sizeX_i;
                   sy <= bus.sizeY_i;
                   i  <= '0;
                 end
        S_SETUP: k <= kmin;
        S_READ:  if (!last_k) k <= k + SIZE_W'(1);
        S_WRITE: if (!last_i) i <= i + IW'(1);
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.rd_en_o   = rd_en;
  assign bus.addrX_o   = k;
  assign bus.addrY_o   = addr_y;
  assign bus.mac_en_o  = mac_en_q;
  assign bus.acc_clr_o = acc_clr;
  assign bus.zwe_o     = zwe;
  assign bus.addrZ_o   = i;

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [15:0] cycles;

  always_ff @(posedge clk) begin
    if (rst)                               cycles <= '0;
    else if (state == S_IDLE && bus.start_i) cycles <= '0;
    else if (busy && cycles != 16'hFFFF)   cycles <= cycles + 16'd1;
  end

  assign bus.cycles_o = cycles;
`endif
endmodule
